// File: rtl/debug_host_master_if.sv
// Command/response and serial-line signals of the UART debug host master.
// The master modport is the view of debug_host_master itself.
interface debug_host_master_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic [7:0] rsp_len;
  logic       cmd_ready;
  logic       tx;
  logic       rx;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       done;
  logic       timeout_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_byte, rsp_len, rx,
    output cmd_ready, tx, rsp_data, rsp_valid, done, timeout_err, frame_err, busy
  );

  modport slave (
    output cmd_valid, cmd_byte, rsp_len, rx,
    input  cmd_ready, tx, rsp_data, rsp_valid, done, timeout_err, frame_err, busy
  );
endinterface

// File: rtl/debug_host_master.sv
// Host-side UART debug master: sends one 8N1 command byte on tx, then collects
// a counted number of 8N1 response bytes from rx, with start-bit timeout.
module debug_host_master #(
  parameter int BIT_CLKS     = 2604,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                clk,
  input  logic                reset,
  debug_host_master_if.master bus
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_BITS - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  idle_bits;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic [7:0]       bytes_left;

  logic tx_q;
  logic cmd_ready_q;
  logic [7:0] rsp_data_q;
  logic rsp_valid_q;
  logic done_q;
  logic timeout_q;
  logic frame_q;

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  // rx is asynchronous to clk; rx_prev gives a clean falling-edge detect for start bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      idle_bits   <= '0;
      bit_idx     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bytes_left  <= '0;
      tx_q        <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            tx_shift    <= bus.cmd_byte;
            bytes_left  <= bus.rsp_len;
            timeout_q   <= 1'b0;
            frame_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            tx_q        <= 1'b0;
            bit_cnt     <= '0;
            state       <= TX_START;
          end
        end

        TX_START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            tx_q     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            state    <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        TX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              tx_q     <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        TX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            idle_bits <= '0;
            if (bytes_left != 8'd0) begin
              state <= RX_WAIT;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // A start edge wins over a timeout that would expire on the same clock.
        RX_WAIT: begin
          if (rx_fall) begin
            bit_cnt <= '0;
            state   <= RX_START;
          end else if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (idle_bits == TO_LAST) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= DONE;
            end else begin
              idle_bits <= idle_bits + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (!rx_sync) begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              idle_bits <= '0;
              state     <= RX_WAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // A byte with a bad stop bit still consumes one slot of the response count.
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt    <= '0;
            idle_bits  <= '0;
            bytes_left <= bytes_left - 8'd1;
            if (rx_sync) begin
              rsp_data_q  <= rx_shift;
              rsp_valid_q <= 1'b1;
            end else begin
              frame_q <= 1'b1;
            end
            if (bytes_left == 8'd1) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RX_WAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DONE: begin
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          tx_q        <= 1'b1;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx          = tx_q;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = ~cmd_ready_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_q;
  assign bus.frame_err   = frame_q;

endmodule

// File: tb/tb_debug_host_master.sv
// Randomized self-checking bench for debug_host_master: a serial BFM answers each
// command and a queue-based model predicts tx frames, response bytes, flags and timing.
module tb_debug_host_master;

  localparam int BIT_CLKS     = 4;
  localparam int TIMEOUT_BITS = 8;
  localparam int FRAME_CLKS   = 10 * BIT_CLKS;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;

  logic clk = 1'b0;
  logic reset = 1'b1;

  debug_host_master_if bus();

  debug_host_master #(
    .BIT_CLKS    (BIT_CLKS),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] bfm_bytes [16];
  logic [7:0] got_q [$];
  int         last_rv_cyc;

  logic [9:0] frame_got;
  logic       done_seen;
  int         done_cyc;
  logic       ready_at_done;
  logic       to_at_done;
  logic       fe_at_done;
  logic       done_after;
  logic       ready_after;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.rsp_valid === 1'b1) begin
      got_q.push_back(bus.rsp_data);
      last_rv_cyc = cyc;
    end
  end

  // Must be called right at a falling clock edge; each bit is held BIT_CLKS clocks.
  task automatic send_byte(input logic [7:0] d, input logic good_stop);
    logic [9:0] f;
    f = {good_stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    bus.rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] len, input int n_send,
                               input logic [15:0] bad_mask, input logic glitch);
    int         c0;
    int         first_gap;
    logic [9:0] frame_exp;
    logic [7:0] exp_q [$];
    logic       exp_to;
    logic       exp_fe;

    frame_exp = {1'b1, cmd, 1'b0};
    exp_to    = (n_send < int'(len));
    exp_fe    = 1'b0;
    for (int k = 0; k < n_send; k++) begin
      if (bad_mask[k]) exp_fe = 1'b1;
      else exp_q.push_back(bfm_bytes[k]);
    end
    first_gap = int'($urandom_range(1, 4));

    got_q.delete();
    last_rv_cyc = -1;
    done_seen   = 1'b0;
    done_cyc    = 0;
    frame_got   = '0;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = cmd;
    bus.rsp_len   = len;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.cmd_valid = 1'b0;
    checkOutput("accept_tx_low", bus.tx, 0);
    checkOutput("accept_busy", bus.busy, 1);
    checkOutput("accept_flags_clear", {bus.timeout_err, bus.frame_err}, 0);

    fork
      begin
        for (int j = 0; j < 10; j++) begin
          repeat ((j == 0) ? BIT_CLKS / 2 : BIT_CLKS) @(posedge clk);
          #1;
          frame_got[j] = bus.tx;
        end
      end
      begin
        if (n_send > 0 || glitch) begin
          repeat (FRAME_CLKS + first_gap) @(negedge clk);
          if (glitch) begin
            bus.rx = 1'b0;
            @(negedge clk);
            bus.rx = 1'b1;
            repeat (6) @(negedge clk);
          end
          for (int k = 0; k < n_send; k++) begin
            send_byte(bfm_bytes[k], !bad_mask[k]);
            if (bad_mask[k]) repeat (BIT_CLKS) @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
      end
      begin
        for (int k = 0; k < 3000 && !done_seen; k++) begin
          @(posedge clk);
          #1;
          if (bus.done === 1'b1) begin
            done_seen     = 1'b1;
            done_cyc      = cyc;
            ready_at_done = bus.cmd_ready;
            to_at_done    = bus.timeout_err;
            fe_at_done    = bus.frame_err;
          end
        end
        if (done_seen) begin
          @(posedge clk);
          #1;
          done_after  = bus.done;
          ready_after = bus.cmd_ready;
        end
      end
    join

    checkOutput("tx_frame", frame_got, frame_exp);
    checkOutput("done_seen", done_seen, 1);
    if (done_seen) begin
      checkOutput("done_ready_low", ready_at_done, 0);
      checkOutput("done_one_cycle", done_after, 0);
      checkOutput("ready_after_done", ready_after, 1);
      checkOutput("timeout_err", to_at_done, exp_to);
      checkOutput("frame_err", fe_at_done, exp_fe);
      // Accept cycle plus a 40-clock frame: done shows 40 edges after the accept edge.
      if (len == 8'd0)
        checkOutput("done_latency_tx_only", done_cyc - c0, FRAME_CLKS);
      else if (exp_to && n_send == 0 && !glitch)
        checkOutput("timeout_latency", done_cyc - c0, FRAME_CLKS + TIMEOUT_CLKS);
      else if (exp_to && n_send > 0)
        checkOutput("timeout_latency", done_cyc - last_rv_cyc, TIMEOUT_CLKS);
      else if (!exp_to && !bad_mask[n_send-1])
        checkOutput("done_after_last_stop", done_cyc - last_rv_cyc, 0);
    end
    checkOutput("rsp_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      checkOutput("rsp_byte", got_q[k], exp_q[k]);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  cmd;
    logic [7:0]  len;
    int          n;
    logic [15:0] mask;
    logic        g;

    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = '0;
    bus.rsp_len   = '0;
    bus.rx        = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", bus.tx, 1);
    checkOutput("reset_ready", bus.cmd_ready, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_rsp", {bus.rsp_valid, bus.rsp_data}, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_flags", {bus.timeout_err, bus.frame_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] transmit-only command 0xA5");
    applyStimulus(8'hA5, 8'd0, 0, 16'h0000, 1'b0);

    $display("[TB] three good response bytes");
    bfm_bytes[0] = 8'h11; bfm_bytes[1] = 8'h22; bfm_bytes[2] = 8'hFF;
    applyStimulus(8'h01, 8'd3, 3, 16'h0000, 1'b0);

    $display("[TB] one byte then silence");
    bfm_bytes[0] = 8'h5E;
    applyStimulus(8'h02, 8'd2, 1, 16'h0000, 1'b0);

    $display("[TB] bad stop bit then good byte");
    bfm_bytes[0] = 8'h3C; bfm_bytes[1] = 8'h42;
    applyStimulus(8'h03, 8'd2, 2, 16'h0001, 1'b0);

    $display("[TB] rx glitch before a good byte");
    bfm_bytes[0] = 8'h77;
    applyStimulus(8'h04, 8'd1, 1, 16'h0000, 1'b1);

    $display("[TB] reset during command data bits");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = 8'h00;
    bus.rsp_len   = 8'd0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_tx_low", bus.tx, 0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", bus.tx, 1);
    checkOutput("async_reset_ready", bus.cmd_ready, 1);
    checkOutput("async_reset_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(8'hC3, 8'd0, 0, 16'h0000, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      cmd  = 8'($urandom);
      len  = 8'($urandom_range(0, 4));
      n    = int'(len);
      mask = '0;
      g    = 1'b0;
      if (len != 8'd0) begin
        if ($urandom_range(0, 3) == 0) n = n - 1;
        for (int k = 0; k < n; k++) begin
          bfm_bytes[k] = 8'($urandom);
          mask[k]      = ($urandom_range(0, 4) == 0);
        end
        if (n < int'(len) && n > 0) mask[n-1] = 1'b0;
        g = (n > 0) && ($urandom_range(0, 3) == 0);
      end
      applyStimulus(cmd, len, n, mask, g);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
